// File: rtl/bram_arbiter.sv
// Two-master round-robin arbiter in front of a single BRAM port (picorv32 native handshake).
// One clean handshake per grant; a forced IDLE cycle swallows the wrapper's trailing ready.
module bram_arbiter #(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_valid,
  output logic          m0_ready,
  input  logic [AW-1:0] m0_addr,
  input  logic [31:0]   m0_wdata,
  input  logic [3:0]    m0_wstrb,
  output logic [31:0]   m0_rdata,
  input  logic          m1_valid,
  output logic          m1_ready,
  input  logic [AW-1:0] m1_addr,
  input  logic [31:0]   m1_wdata,
  input  logic [3:0]    m1_wstrb,
  output logic [31:0]   m1_rdata,
  output logic          s_valid,
  input  logic          s_ready,
  output logic [AW-1:0] s_addr,
  output logic [31:0]   s_wdata,
  output logic [3:0]    s_wstrb,
  input  logic [31:0]   s_rdata,
  output logic          grant,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;
  logic   r_last;
  logic   r_grant;
  logic   r_busy;
  logic   w_pick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
      r_grant <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_busy  <= (w_state_next != IDLE);
      if (r_state == IDLE && w_state_next != IDLE) begin
        r_last  <= w_pick;
        r_grant <= w_pick;
      end
    end
  end

  // Under contention the master that did not win last time goes next.
  always_comb begin
    w_pick       = 1'b0;
    w_state_next = r_state;
    if (m0_valid && m1_valid) begin
      w_pick = ~r_last;
    end else if (m1_valid) begin
      w_pick = 1'b1;
    end
    case (r_state)
      IDLE: begin
        if (m0_valid || m1_valid) begin
          w_state_next = w_pick ? BUSY1 : BUSY0;
        end
      end
      BUSY0, BUSY1: begin
        if (s_ready) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // s_ready is only honoured in a BUSY state, so the stale pulse in IDLE is dropped.
  always_comb begin
    s_valid  = 1'b0;
    s_wstrb  = 4'h0;
    m0_ready = 1'b0;
    m1_ready = 1'b0;
    s_addr   = r_grant ? m1_addr : m0_addr;
    s_wdata  = r_grant ? m1_wdata : m0_wdata;
    case (r_state)
      BUSY0: begin
        s_valid  = 1'b1;
        s_wstrb  = m0_wstrb;
        m0_ready = s_ready;
      end
      BUSY1: begin
        s_valid  = 1'b1;
        s_wstrb  = m1_wstrb;
        m1_ready = s_ready;
      end
      default: begin
        s_valid = 1'b0;
      end
    endcase
  end

  assign m0_rdata = s_rdata;
  assign m1_rdata = s_rdata;
  assign grant    = r_grant;
  assign busy     = r_busy;

endmodule

// File: tb/tb_bram_arbiter.sv
// Scoreboard bench for bram_arbiter: per-master expected queues filled at issue time,
// a negedge monitor pops and compares on every ready pulse, plus a BRAM wrapper model.
module tb_bram_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_valid = 1'b0, m1_valid = 1'b0;
  logic        m0_ready, m1_ready;
  logic [31:0] m0_addr = '0, m1_addr = '0;
  logic [31:0] m0_wdata = '0, m1_wdata = '0;
  logic [3:0]  m0_wstrb = '0, m1_wstrb = '0;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_valid;
  logic        s_ready = 1'b0;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_wstrb;
  logic [31:0] s_rdata = '0;
  logic        grant, busy;

  bram_arbiter #(.AW(32)) dut (
    .clk(clk), .rst(rst),
    .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_rdata(s_rdata),
    .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
  } exp_t;

  exp_t        exp_q0[$];
  exp_t        exp_q1[$];
  int          ready_seq[$];
  int          ready_cyc[$];
  logic [31:0] model_mem[256];
  logic [31:0] bram[256];
  logic [31:0] last_rdata[2];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          stale_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // BRAM wrapper: ready is valid delayed one cycle, data read registered.
  always @(posedge clk) begin
    s_ready <= s_valid;
    if (s_valid) begin
      s_rdata <= bram[s_addr[9:2]];
      for (int b = 0; b < 4; b++)
        if (s_wstrb[b]) bram[s_addr[9:2]][8*b +: 8] <= s_wdata[8*b +: 8];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=0x%08h required=0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic chk_ready(input int m, input logic [31:0] rd);
    exp_t e;
    ready_seq.push_back(m);
    ready_cyc.push_back(cyc);
    last_rdata[m] = rd;
    checks++;
    if ((m == 0 && exp_q0.size() == 0) || (m == 1 && exp_q1.size() == 0)) begin
      errors++;
      $display("FAIL spurious_ready: m%0d_ready=1 required=0 (no request pending, cycle %0d)", m, cyc);
      return;
    end
    e = (m == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
    $display("txn m%0d addr=0x%08h wstrb=%h wdata=0x%08h rdata=0x%08h cycle=%0d",
             m, s_addr, s_wstrb, s_wdata, rd, cyc);
    chk("grant_at_ready", {31'd0, grant}, m);
    chk("s_addr", s_addr, e.addr);
    chk("s_wstrb", {28'd0, s_wstrb}, {28'd0, e.wstrb});
    if (e.wstrb != 4'h0) chk("s_wdata", s_wdata, e.wdata);
    else chk("rdata", rd, e.rdata);
  endtask

  // Monitor: invariants every cycle, scoreboard pop on each ready pulse.
  always @(negedge clk) begin
    if (!rst) begin
      if (s_ready && !busy) stale_cnt++;
      chk("s_valid_vs_busy", {31'd0, s_valid}, {31'd0, busy});
      chk("both_ready", {31'd0, m0_ready && m1_ready}, 32'd0);
      if (!s_valid) begin
        chk("idle_wstrb", {28'd0, s_wstrb}, 32'd0);
        chk("idle_ready", {30'd0, m1_ready, m0_ready}, 32'd0);
      end
      if (m0_ready) chk_ready(0, m0_rdata);
      if (m1_ready) chk_ready(1, m1_rdata);
    end
  end

  task automatic drive(input int m, input logic v, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s);
    if (m == 0) begin
      m0_valid = v; m0_addr = a; m0_wdata = d; m0_wstrb = s;
    end else begin
      m1_valid = v; m1_addr = a; m1_wdata = d; m1_wstrb = s;
    end
  endtask

  // Call at posedge+1; returns at posedge+1 after the handshake. lat = ready cycle - issue cycle.
  task automatic access(input int m, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, output int lat);
    exp_t e;
    int   t0;
    bit   done;
    e.addr  = addr;
    e.wdata = wdata;
    e.wstrb = wstrb;
    e.rdata = model_mem[addr[9:2]];
    for (int b = 0; b < 4; b++)
      if (wstrb[b]) model_mem[addr[9:2]][8*b +: 8] = wdata[8*b +: 8];
    if (m == 0) exp_q0.push_back(e);
    else exp_q1.push_back(e);
    drive(m, 1'b1, addr, wdata, wstrb);
    t0   = cyc;
    done = 0;
    lat  = -1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if ((m == 0 && m0_ready) || (m == 1 && m1_ready)) begin
        done = 1;
        lat  = cyc - t0;
      end
    end
    if (!done) begin
      errors++;
      checks++;
      $display("FAIL timeout: m%0d ready actual=0 required=1 within 100 cycles", m);
      if (m == 0) void'(exp_q0.pop_back());
      else void'(exp_q1.pop_back());
    end
    @(posedge clk);
    #1;
    drive(m, 1'b0, addr, wdata, 4'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_s_valid", {31'd0, s_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_grant", {31'd0, grant}, 32'd0);
    chk("rst_s_wstrb", {28'd0, s_wstrb}, 32'd0);
    chk("rst_ready", {30'd0, m1_ready, m0_ready}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat;
    int base_seq, base_stale, hung;
    for (int i = 0; i < 256; i++) begin
      bram[i]      = 32'h0;
      model_mem[i] = 32'h0;
    end
    do_reset();

    // Single read from m0, then m1 write, then m0 reads the written word.
    access(0, 32'h10, 32'h0, 4'h0, lat);
    chk("read_latency", lat, 32'd2);
    access(1, 32'h20, 32'hDEADBEEF, 4'hF, lat);
    chk("write_latency", lat, 32'd2);
    access(0, 32'h20, 32'h0, 4'h0, lat);
    chk("readback", last_rdata[0], 32'hDEADBEEF);

    // Continuous contention straight after reset: 0,1,0,1,... every 3 cycles.
    do_reset();
    base_seq = ready_seq.size();
    fork
      for (int k = 0; k < 4; k++) access(0, 32'h40 + 4 * k, 32'h1000 + k, 4'hF, lat);
      for (int k = 0; k < 4; k++) access(1, 32'h140 + 4 * k, 32'h2000 + k, 4'hF, lat);
    join
    chk("contention_count", ready_seq.size() - base_seq, 32'd8);
    for (int k = 0; k < 8 && base_seq + k < ready_seq.size(); k++) begin
      chk("contention_grant", ready_seq[base_seq + k], k % 2);
      if (k > 0) chk("contention_gap", ready_cyc[base_seq + k] - ready_cyc[base_seq + k - 1], 32'd3);
    end

    // Back-to-back m0 requests: one ready each, every stale ready swallowed.
    repeat (3) @(posedge clk);
    #1;
    base_seq   = ready_seq.size();
    base_stale = stale_cnt;
    for (int k = 0; k < 5; k++) access(0, 32'h40 + 4 * k, 32'h0, 4'h0, lat);
    repeat (3) @(posedge clk);
    #1;
    chk("b2b_ready_count", ready_seq.size() - base_seq, 32'd5);
    chk("stale_ready_count", stale_cnt - base_stale, 32'd5);

    // Reset while m1 is granted: access abandoned, no ready, then a clean retry.
    drive(1, 1'b1, 32'h180, 32'hCAFEF00D, 4'hF);
    hung = 1;
    for (int i = 0; i < 20 && hung; i++) begin
      @(negedge clk);
      if (busy && grant) hung = 0;
    end
    chk("reach_busy1", hung, 32'd0);
    rst = 1'b1;
    #1;
    chk("midrst_s_valid", {31'd0, s_valid}, 32'd0);
    chk("midrst_m1_ready", {31'd0, m1_ready}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    drive(1, 1'b0, 32'h180, 32'h0, 4'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    access(1, 32'h180, 32'h0BADF00D, 4'hF, lat);
    chk("retry_latency", lat, 32'd2);
    access(1, 32'h180, 32'h0, 4'h0, lat);
    chk("retry_readback", last_rdata[1], 32'h0BADF00D);

    // Randomised traffic, disjoint address regions per master.
    fork
      for (int k = 0; k < 12; k++) begin
        logic [3:0] s;
        s = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
        access(0, {24'd0, 2'b00, 4'($urandom_range(0, 15)), 2'b00}, $urandom, s, lat);
      end
      for (int k = 0; k < 12; k++) begin
        logic [3:0] s;
        s = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
        access(1, {24'd1, 2'b00, 4'($urandom_range(0, 15)), 2'b00}, $urandom, s, lat);
      end
    join
    repeat (4) @(posedge clk);
    #1;
    chk("q0_drained", exp_q0.size(), 32'd0);
    chk("q1_drained", exp_q1.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time actual=200000 required=less");
    $fatal(1, "watchdog expired");
  end

endmodule
